// File: rtl/sr_cmd_gen.sv
// rtl/sr_cmd_gen.sv - debounced set/reset request to one-cycle S/R command generator
module sr_cmd_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter bit R_PRIORITY      = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_req,
    input  logic rst_req,
    output logic S,
    output logic R,
    output logic conflict
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    // Channel 0 carries the set request, channel 1 the reset request.
    logic [1:0]    raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    deb;
    logic [1:0]    deb_q;
    logic [CW-1:0] cnt [2];
    logic [1:0]    rise;
    logic          s_nxt;
    logic          r_nxt;
    logic          c_nxt;

    assign raw = {rst_req, set_req};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= '0;
            sync2  <= '0;
            deb    <= '0;
            deb_q  <= '0;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_q <= deb;
            for (int ch = 0; ch < 2; ch++) begin
                // Any return to the accepted level restarts the stability count.
                if (sync2[ch] == deb[ch]) begin
                    cnt[ch] <= '0;
                end else if (cnt[ch] == CNT_MAX) begin
                    deb[ch] <= sync2[ch];
                    cnt[ch] <= '0;
                end else begin
                    cnt[ch] <= cnt[ch] + CW'(1);
                end
            end
        end
    end

    assign rise = deb & ~deb_q;

    always_comb begin
        s_nxt = rise[0];
        r_nxt = rise[1];
        c_nxt = 1'b0;
        // Only one command may ever reach the downstream latch per cycle.
        if (rise[0] && rise[1]) begin
            s_nxt = ~R_PRIORITY;
            r_nxt = R_PRIORITY;
            c_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S        <= 1'b0;
            R        <= 1'b0;
            conflict <= 1'b0;
        end else begin
            S        <= s_nxt;
            R        <= r_nxt;
            conflict <= c_nxt;
        end
    end

endmodule
